// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_capture - recovers hex digits from a multiplexed 7-segment bus through a stability filter.
// Build macro SEG7_ACTIVE_LOW_EN inverts seg_i/an_i for common-anode displays.  Rev 1.0
// ---------------------------------------------------------------------------
module seg7_scan_capture #(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_i,
  input  logic [NUM_DIG-1:0]   an_i,
  output logic [4*NUM_DIG-1:0] dig_val_o,
  output logic [NUM_DIG-1:0]   dig_vld_o,
  output logic                 upd_o,
  output logic [2:0]           upd_idx_o,
  output logic [3:0]           upd_val_o,
  output logic                 err_o,
  output logic                 frame_o
);

  localparam int              CW       = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYC - 1);
  localparam logic [1:0]      S_SEEK   = 2'd0;
  localparam logic [1:0]      S_TRACK  = 2'd1;
  localparam logic [1:0]      S_HOLD   = 2'd2;

  logic [6:0]           seg_in, seg_s1_q, seg_s2_q, ref_seg_q, ref_seg_d;
  logic [NUM_DIG-1:0]   an_in, an_s1_q, an_s2_q, ref_an_q, ref_an_d;
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 eval_q, eval_d;
  logic [4*NUM_DIG-1:0] dig_val_q, dig_val_d;
  logic [NUM_DIG-1:0]   dig_vld_q, dig_vld_d;
  logic                 upd_q, upd_d, err_q, err_d, frame_q, frame_d;
  logic [2:0]           upd_idx_q, upd_idx_d;
  logic [3:0]           upd_val_q, upd_val_d;
  logic [4:0]           dec;
  logic                 usable, match;

`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_in = ~seg_i;
  assign an_in  = ~an_i;
`else
  assign seg_in = seg_i;
  assign an_in  = an_i;
`endif

  // Returns {legal, value}; blank and illegal patterns both report legal=0.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h3F: seg_decode = 5'h10;  7'h06: seg_decode = 5'h11;
      7'h5B: seg_decode = 5'h12;  7'h4F: seg_decode = 5'h13;
      7'h66: seg_decode = 5'h14;  7'h6D: seg_decode = 5'h15;
      7'h7D: seg_decode = 5'h16;  7'h07: seg_decode = 5'h17;
      7'h7F: seg_decode = 5'h18;  7'h67: seg_decode = 5'h19;
      7'h77: seg_decode = 5'h1A;  7'h7C: seg_decode = 5'h1B;
      7'h39: seg_decode = 5'h1C;  7'h5E: seg_decode = 5'h1D;
      7'h79: seg_decode = 5'h1E;  7'h71: seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  assign usable = $onehot(an_s2_q);
  assign match  = (seg_s2_q == ref_seg_q) && (an_s2_q == ref_an_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1_q  <= '0;  seg_s2_q  <= '0;
      an_s1_q   <= '0;  an_s2_q   <= '0;
      ref_seg_q <= '0;  ref_an_q  <= '0;
      state_q   <= S_SEEK;
      cnt_q     <= '0;
      eval_q    <= 1'b0;
      dig_val_q <= '0;  dig_vld_q <= '0;
      upd_q     <= 1'b0; upd_idx_q <= '0; upd_val_q <= '0;
      err_q     <= 1'b0; frame_q   <= 1'b0;
    end else begin
      seg_s1_q  <= seg_in;    seg_s2_q  <= seg_s1_q;
      an_s1_q   <= an_in;     an_s2_q   <= an_s1_q;
      ref_seg_q <= ref_seg_d; ref_an_q  <= ref_an_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      eval_q    <= eval_d;
      dig_val_q <= dig_val_d; dig_vld_q <= dig_vld_d;
      upd_q     <= upd_d;     upd_idx_q <= upd_idx_d; upd_val_q <= upd_val_d;
      err_q     <= err_d;     frame_q   <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_seg_d = ref_seg_q;
    ref_an_d  = ref_an_q;
    eval_d    = 1'b0;
    if (!usable) begin
      state_d = S_SEEK;
      cnt_d   = '0;
    end else if (state_q != S_SEEK && match) begin
      // HOLD leaves cnt parked at STABLE_CYC so it never wraps.
      if (state_q == S_TRACK) begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          eval_d  = 1'b1;
        end
      end
    end else begin
      ref_seg_d = seg_s2_q;
      ref_an_d  = an_s2_q;
      cnt_d     = CNT_ONE;
      if (STABLE_CYC == 1) begin
        state_d = S_HOLD;
        eval_d  = 1'b1;
      end else begin
        state_d = S_TRACK;
      end
    end
  end

  always_comb begin
    dec       = seg_decode(ref_seg_q);
    dig_val_d = dig_val_q;
    dig_vld_d = dig_vld_q;
    upd_d     = 1'b0;
    upd_idx_d = '0;
    upd_val_d = '0;
    err_d     = 1'b0;
    if (eval_q) begin
      if (dec[4]) begin
        upd_d     = 1'b1;
        upd_val_d = dec[3:0];
      end else if (ref_seg_q != 7'h00) begin
        err_d = 1'b1;
      end
      for (int k = 0; k < NUM_DIG; k++) begin
        if (ref_an_q[k]) begin
          if (dec[4]) begin
            dig_val_d[4*k +: 4] = dec[3:0];
            dig_vld_d[k]        = 1'b1;
            upd_idx_d           = 3'(k);
          end else if (ref_seg_q == 7'h00) begin
            dig_vld_d[k] = 1'b0;
          end
        end
      end
    end
    frame_d = upd_d & ref_an_q[NUM_DIG-1] & (&dig_vld_d);
  end

  assign dig_val_o = dig_val_q;
  assign dig_vld_o = dig_vld_q;
  assign upd_o     = upd_q;
  assign upd_idx_o = upd_idx_q;
  assign upd_val_o = upd_val_q;
  assign err_o     = err_q;
  assign frame_o   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// tb_seg7_scan_capture - randomized scoreboard bench for seg7_scan_capture.
module tb_seg7_scan_capture;

  localparam int NUM_DIG    = 4;
  localparam int STABLE_CYC = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [6:0]           seg_i;
  logic [NUM_DIG-1:0]   an_i;
  logic [4*NUM_DIG-1:0] dig_val_o;
  logic [NUM_DIG-1:0]   dig_vld_o;
  logic                 upd_o, err_o, frame_o;
  logic [2:0]           upd_idx_o;
  logic [3:0]           upd_val_o;

  seg7_scan_capture #(.NUM_DIG(NUM_DIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .an_i(an_i),
    .dig_val_o(dig_val_o), .dig_vld_o(dig_vld_o), .upd_o(upd_o),
    .upd_idx_o(upd_idx_o), .upd_val_o(upd_val_o), .err_o(err_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int                 cyc;
    logic [6:0]         seg;
    logic [NUM_DIG-1:0] an;
  } ev_t;
  ev_t q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus-side model: a run of STABLE_CYC identical one-hot pairs yields one evaluation,
  // visible three edges after the edge that completed the run.
  logic [6:0]         prev_seg = '0;
  logic [NUM_DIG-1:0] prev_an  = '0;
  int                 run_len  = 0;

  task automatic step(input logic [6:0] s, input logic [NUM_DIG-1:0] a, input logic r);
    int e;
    @(negedge clk);
    e     = cyc + 1;
    rst_n = r;
`ifdef SEG7_ACTIVE_LOW_EN
    seg_i = ~s;
    an_i  = ~a;
`else
    seg_i = s;
    an_i  = a;
`endif
    if (!r) begin
      run_len = 0;
      while (q.size() > 0 && q[$].cyc >= e) void'(q.pop_back());
    end else if ($onehot(a)) begin
      if (run_len > 0 && s == prev_seg && a == prev_an) run_len++;
      else run_len = 1;
      prev_seg = s;
      prev_an  = a;
      if (run_len == STABLE_CYC) q.push_back('{e + 3, s, a});
    end else begin
      run_len = 0;
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [NUM_DIG-1:0] a, input int n);
    repeat (n) step(s, a, 1'b1);
  endtask

  // Monitor: owns the model of the digit registers and compares every cycle.
  logic [4*NUM_DIG-1:0] m_val = '0;
  logic [NUM_DIG-1:0]   m_vld = '0;

  always begin
    ev_t  ev;
    int   k, v;
    logic exp_upd, exp_err, exp_frm;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_val = '0;
      m_vld = '0;
      chk("rst_upd",     64'(upd_o),     64'(0));
      chk("rst_err",     64'(err_o),     64'(0));
      chk("rst_frame",   64'(frame_o),   64'(0));
      chk("rst_idx",     64'(upd_idx_o), 64'(0));
      chk("rst_val",     64'(upd_val_o), 64'(0));
      chk("rst_dig_val", 64'(dig_val_o), 64'(0));
      chk("rst_dig_vld", 64'(dig_vld_o), 64'(0));
    end else begin
      exp_upd = 1'b0; exp_err = 1'b0; exp_frm = 1'b0; k = 0; v = -1;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        ev = q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL stale_event: got none expected event at cycle %0d (now %0d)", ev.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        for (int i = 0; i < NUM_DIG; i++) if (ev.an[i]) k = i;
        for (int i = 0; i < 16; i++) if (codes[i] == ev.seg) v = i;
        if (v >= 0) begin
          m_val[4*k +: 4] = 4'(v);
          m_vld[k]        = 1'b1;
          exp_upd         = 1'b1;
          exp_frm         = (k == NUM_DIG - 1) && (&m_vld);
        end else if (ev.seg == 7'h00) begin
          m_vld[k] = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
      chk("upd",     64'(upd_o),     64'(exp_upd));
      chk("err",     64'(err_o),     64'(exp_err));
      chk("frame",   64'(frame_o),   64'(exp_frm));
      chk("dig_val", 64'(dig_val_o), 64'(m_val));
      chk("dig_vld", 64'(dig_vld_o), 64'(m_vld));
      if (exp_upd) begin
        chk("upd_idx", 64'(upd_idx_o), 64'(k));
        chk("upd_val", 64'(upd_val_o), 64'(v));
      end
    end
  end

  initial begin
    logic [6:0]         s;
    logic [NUM_DIG-1:0] a;
    int                 r, n;
    rst_n = 1'b0;
    seg_i = '0;
    an_i  = '0;
    repeat (3) step(7'($urandom), NUM_DIG'($urandom), 1'b0);
    hold(7'h00, 4'b0000, 4);
    // Single capture, then sub-threshold holds, then illegal and blank patterns.
    hold(7'h3F, 4'b0001, 10);
    hold(7'h06, 4'b0010, 3);
    hold(7'h5B, 4'b0010, 3);
    hold(7'h01, 4'b0100, 8);
    hold(7'h00, 4'b0001, 8);
    // Full scan pass producing a frame.
    hold(7'h7F, 4'b0001, 8);
    hold(7'h67, 4'b0010, 8);
    hold(7'h77, 4'b0100, 8);
    hold(7'h71, 4'b1000, 8);
    hold(7'h7F, 4'b0011, 10);
    // Reset landing while a pair is still being counted.
    hold(7'h3F, 4'b0001, 4);
    repeat (2) step(7'h3F, 4'b0001, 1'b0);
    hold(7'h00, 4'b0000, 3);
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        for (int d = 0; d < NUM_DIG; d++)
          hold(codes[$urandom_range(0, 15)], NUM_DIG'(1) << d, $urandom_range(STABLE_CYC, 7));
      end
      r = $urandom_range(0, 99);
      a = NUM_DIG'(1) << $urandom_range(0, NUM_DIG - 1);
      if (r < 5) a = '0;
      else if (r < 10) a = NUM_DIG'($urandom);
      r = $urandom_range(0, 99);
      s = codes[$urandom_range(0, 15)];
      if (r < 10) s = 7'h00;
      else if (r < 20) s = 7'($urandom);
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) repeat (2) step(s, a, 1'b0);
      hold(s, a, n);
    end
    hold(7'h00, 4'b0000, 10);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
Inverse of the team's hex-to-7-segment decoder. Monitors a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and recovers the 4-bit hex value shown on each digit. A stability filter rejects scan transients. Used as a display snooper and as the checker on the display path.

Parameters:
NUM_DIG, 4, number of multiplexed digits (2..8).
STABLE_CYC, 4, consecutive identical synchronized samples needed to accept a pair (>=1).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
seg_i  in  7  segment lines, bit0=a .. bit6=g, active-high, asynchronous to clk
an_i  in  NUM_DIG  digit enables, one-hot active-high, asynchronous to clk
dig_val_o  out  4*NUM_DIG  recovered values; digit k in bits [4k+3:4k]
dig_vld_o  out  NUM_DIG  digit k holds a valid value
upd_o  out  1  one-cycle strobe: a digit was captured
upd_idx_o  out  3  index of the captured digit
upd_val_o  out  4  captured value
err_o  out  1  one-cycle strobe: stable pattern is not a legal code
frame_o  out  1  one-cycle strobe: digit NUM_DIG-1 captured while all dig_vld bits are set

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. Reset dominates all other events.
- Reset values: all outputs 0. Synchronizers, counter and FSM are cleared. FSM enters SEEK.
- Input sync: seg_i and an_i pass through two flops. Call the synchronizer output the pair P.
- Pair validity: P is usable only if an_i is exactly one-hot. Zero or multi-hot forces SEEK and clears the counter.
- Code table (value:seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 B:7C C:39 D:5E E:79 F:71.
  - Pattern 00 means "blank".
  - Any other pattern is illegal.
- FSM:
  - SEEK: on a usable P, latch it as the reference, set cnt=1, go to TRACK.
  - TRACK: if P equals the reference, cnt++. If P differs, re-latch P (or go to SEEK if unusable) with cnt=1. When cnt reaches STABLE_CYC, evaluate the pair and go to HOLD.
  - HOLD: stay while P is unchanged. Any change re-latches as in TRACK with cnt=1. Leaving and returning to the same pair counts as a change, so each scan pass produces a new capture.
  - With STABLE_CYC=1, evaluation happens on the same cycle P is latched.
- Evaluation, registered one cycle after cnt reaches STABLE_CYC:
  - Legal code: write dig_val[k], set dig_vld[k], pulse upd_o with upd_idx_o=k and upd_val_o=value.
  - Blank: clear dig_vld[k]; dig_val[k] unchanged; no upd_o.
  - Illegal: pulse err_o; digit k unchanged.
- Latency: a pair applied before edge n and held produces upd_o asserted after edge n+STABLE_CYC+2.
- frame_o pulses in the same cycle as upd_o for index NUM_DIG-1, and only if every dig_vld bit is set after that update.
- At most one evaluation per cycle, so there are no simultaneous-update conflicts.
- Reset asserted mid-TRACK discards the pending capture.
- Counter width is clog2(STABLE_CYC+1). cnt saturates and must not wrap in HOLD.

Optional Feature:
- Macro: SEG7_ACTIVE_LOW_EN
- When defined: seg_i and an_i are inverted at the synchronizer input, for common-anode displays. The code table and all other behaviour are unchanged.
- When undefined: inputs are used as-is (active-high).

Test Plan:
1. Hold rst_n=0 for 3 cycles with random inputs -> all outputs 0. Release with an_i=0 -> still 0, FSM in SEEK.
2. STABLE_CYC=4; an_i=0001, seg_i=3F held 10 cycles -> exactly one upd_o, 6 cycles after apply, with upd_idx=0, upd_val=0; dig_vld=0001.
3. an_i=0010, seg_i=06 held 3 cycles, then seg_i=5B held 3 cycles -> no upd_o, no err_o, dig_vld unchanged.
4. an_i=0100, seg_i=01 held 8 cycles -> one err_o pulse; dig_vld[2]=0. Then seg_i=00 on digit 0 -> dig_vld[0] cleared.
5. Scan digits 0..3 with 7F,67,77,71, 8 cycles each -> dig_val_o=16'hFA98, dig_vld=1111, four upd_o pulses, frame_o coincident with the digit-3 upd_o.
6. an_i=0011, seg_i=7F held 10 cycles -> no capture. Separately, assert rst_n=0 at cnt=3 during a valid hold -> no upd_o, outputs 0.
